// File: rtl/otter_pkg.sv
// Shared OTTER pipeline types and constants.
// Holds the IF/ID bundle consumed by decode.
package otter_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_VEC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] ir;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage: owns the PC, drives the BRAM read port
// and realigns the 1-cycle-late instruction with its PC for decode.
module otter_fetch_stage
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = otter_pkg::RESET_VEC,
   parameter logic [31:0] NOP_INSTR = otter_pkg::NOP_INSTR,
   parameter int          ADDR_W    = 14
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              STALL,
   input  logic              FLUSH,
   input  logic [31:0]       BR_TARGET,
   output logic              MEM_RDEN1,
   output logic [ADDR_W-1:0] MEM_ADDR1,
   input  logic [31:0]       MEM_DOUT1,
   output logic [31:0]       IF_PC,
   output logic [31:0]       IF_PC4,
   output logic [31:0]       IF_IR,
   output logic              IF_VALID,
   output logic              MISALIGN_ERR,
   output logic [31:0]       IF_COUNT
);

   logic [31:0] fpc;
   logic [31:0] pc_d;
   logic        valid_d;
   logic        err;
   logic [31:0] cnt;
   if_id_t      if_id;

   // Read port: word address of fpc; a flush always re-reads, a stall
   // freezes the BRAM output so the held instruction stays stable.
   assign MEM_ADDR1 = fpc[ADDR_W+1:2];
   assign MEM_RDEN1 = RST_N & (~STALL | FLUSH);

   // PC/redirect state; the in-flight PC travels with the BRAM read.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         fpc     <= RESET_VEC;
         pc_d    <= 32'h0;
         valid_d <= 1'b0;
         err     <= 1'b0;
         cnt     <= 32'h0;
      end else if (FLUSH) begin
         fpc     <= {BR_TARGET[31:2], 2'b00};
         valid_d <= 1'b0;
         if (BR_TARGET[1:0] != 2'b00)
            err <= 1'b1;
      end else if (!STALL) begin
         pc_d    <= fpc;
         valid_d <= 1'b1;
         fpc     <= fpc + 32'd4;
         if (valid_d)
            cnt <= cnt + 32'd1;
      end
   end

   // Assemble the IF/ID bundle; bubbles carry a NOP.
   always_comb begin
      if_id.pc    = pc_d;
      if_id.pc4   = pc_d + 32'd4;
      if_id.ir    = valid_d ? MEM_DOUT1 : NOP_INSTR;
      if_id.valid = valid_d;
   end

   assign IF_PC        = if_id.pc;
   assign IF_PC4       = if_id.pc4;
   assign IF_IR        = if_id.ir;
   assign IF_VALID     = if_id.valid;
   assign MISALIGN_ERR = err;
   assign IF_COUNT     = cnt;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed bench for otter_fetch_stage with a synchronous BRAM model.
// Vector table plus hand-written reset sequences.
module tb_otter_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic [31:0] br_target;
   logic        rden;
   logic [13:0] addr;
   logic [31:0] dout;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic [31:0] if_ir;
   logic        if_valid;
   logic        mis_err;
   logic [31:0] if_count;

   logic [31:0] mem [0:16383];

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic        stall;
      logic        flush;
      logic [31:0] tgt;
      logic        rden;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] cnt;
      logic        err;
   } vec_t;

   vec_t vecs [$];

   always #5 clk = ~clk;

   otter_fetch_stage dut (
      .CLK          (clk),
      .RST_N        (rst_n),
      .STALL        (stall),
      .FLUSH        (flush),
      .BR_TARGET    (br_target),
      .MEM_RDEN1    (rden),
      .MEM_ADDR1    (addr),
      .MEM_DOUT1    (dout),
      .IF_PC        (if_pc),
      .IF_PC4       (if_pc4),
      .IF_IR        (if_ir),
      .IF_VALID     (if_valid),
      .MISALIGN_ERR (mis_err),
      .IF_COUNT     (if_count)
   );

   // Synchronous-read BRAM: output holds when not enabled.
   always @(posedge clk) begin
      if (rden)
         dout <= mem[addr];
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic f,
                               input logic [31:0] t, input logic r,
                               input logic v, input logic [31:0] pc,
                               input logic [31:0] ir,
                               input logic [31:0] c, input logic e);
      vec_t x;
      x.stall = s; x.flush = f; x.tgt = t; x.rden = r;
      x.valid = v; x.pc = pc; x.ir = ir; x.cnt = c; x.err = e;
      return x;
   endfunction

   task automatic check_out(input string tag, input logic v,
                            input logic [31:0] pc, input logic [31:0] ir,
                            input logic [31:0] c, input logic e);
      chk({tag, ".valid"}, {31'h0, if_valid}, {31'h0, v});
      chk({tag, ".ir"}, if_ir, ir);
      if (v) begin
         chk({tag, ".pc"}, if_pc, pc);
         chk({tag, ".pc4"}, if_pc4, pc + 32'd4);
      end
      chk({tag, ".cnt"}, if_count, c);
      chk({tag, ".err"}, {31'h0, mis_err}, {31'h0, e});
   endtask

   initial begin
      for (int i = 0; i < 16384; i++)
         mem[i] = 32'hA000_0000 | i;
      mem[0] = 32'h11;
      mem[1] = 32'h22;
      mem[2] = 32'h33;
      dout = 32'h0;

      // stall, flush, target | rden, valid, pc, ir, cnt, err
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0, 32'h11, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h4, 32'h22, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8, 32'h33, 2, 0));
      vecs.push_back(mk(0, 1, 32'h0, 1, 0, 32'h0, 32'h13, 2, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0, 32'h11, 2, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h4, 32'h22, 3, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h4, 32'h22, 3, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h4, 32'h22, 3, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8, 32'h33, 4, 0));
      vecs.push_back(mk(0, 1, 32'h100, 1, 0, 32'h0, 32'h13, 4, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h100, 32'hA000_0040, 4, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h104, 32'hA000_0041, 5, 0));
      vecs.push_back(mk(1, 1, 32'h200, 1, 0, 32'h0, 32'h13, 5, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h200, 32'hA000_0080, 5, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h204, 32'hA000_0081, 6, 0));
      vecs.push_back(mk(0, 1, 32'h102, 1, 0, 32'h0, 32'h13, 6, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h100, 32'hA000_0040, 6, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h104, 32'hA000_0041, 7, 1));
      vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0, 32'h13, 7, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'hA000_3FFF, 7, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0, 32'h11, 8, 1));

      // Reset held 3 edges; last edge also carries a flush to be ignored.
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      br_target = 32'h0;
      #1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            flush = 1'b1;
            br_target = 32'h300;
         end
         #1;
         chk($sformatf("rst%0d.rden", i), {31'h0, rden}, 32'h0);
         @(posedge clk);
         #1;
         check_out($sformatf("rst%0d", i), 1'b0, 32'h0, 32'h13, 0, 0);
      end
      rst_n = 1'b1;
      flush = 1'b0;
      br_target = 32'h0;

      foreach (vecs[k]) begin
         stall = vecs[k].stall;
         flush = vecs[k].flush;
         br_target = vecs[k].tgt;
         #1;
         chk($sformatf("v%0d.rden", k), {31'h0, rden},
             {31'h0, vecs[k].rden});
         @(posedge clk);
         #1;
         check_out($sformatf("v%0d", k), vecs[k].valid, vecs[k].pc,
                   vecs[k].ir, vecs[k].cnt, vecs[k].err);
      end

      // Reset mid-run with stall and flush pending: reset wins.
      rst_n = 1'b0;
      stall = 1'b1;
      flush = 1'b1;
      br_target = 32'h402;
      #1;
      chk("midrst.rden", {31'h0, rden}, 32'h0);
      @(posedge clk);
      #1;
      check_out("midrst", 1'b0, 32'h0, 32'h13, 0, 0);
      rst_n = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      br_target = 32'h0;
      @(posedge clk);
      #1;
      check_out("after_rst", 1'b1, 32'h0, 32'h11, 0, 0);
      @(posedge clk);
      #1;
      check_out("after_rst2", 1'b1, 32'h4, 32'h22, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
